inttofloat_arbiter: RTL
=======================

# inttofloat_arbiter

Round-robin scheduler that shares one multi-cycle `inttofloat` converter among `NREQ` requesters, typically synth voices that emit 16-bit signed samples needing float conversion. It latches one requester's sample and pulses the converter's `reset` to load it. It then waits for `done` and returns the float result to that requester with a one-cycle acknowledge. A watchdog keeps a stalled converter from hanging the requesters.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2–8)
- `INT_WIDTH`, 16, signed integer sample width
- `FLOAT_WIDTH`, 32, IEEE-754 single result width
- `TIMEOUT`, 15, max WAIT cycles before abort

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `req`  in  NREQ  bit i = requester i has a pending sample; held high until `ack[i]`
- `req_data`  in  NREQ*INT_WIDTH  slice i = requester i's sample; stable while `req[i]` is high
- `ack`  out  NREQ  one-hot, one-cycle pulse; `result` is valid for requester i
- `result`  out  FLOAT_WIDTH  converted value, updated only with `ack`
- `busy`  out  1  high in any state other than IDLE
- `timeout_err`  out  1  sticky; set when a conversion times out
- `conv_reset`  out  1  drives converter `reset`, which loads `conv_intin`
- `conv_intin`  out  INT_WIDTH  drives converter `intin`
- `conv_floatout`  in  FLOAT_WIDTH  converter `floatout`
- `conv_done`  in  1  converter `done`

## Operation
- Reset values: state IDLE; `ack` 0; `result` 0; `conv_intin` 0; `busy` 0; `timeout_err` 0; `last_grant` NREQ-1, so requester 0 wins first. `conv_reset` is 1 while `reset` is high.
- States:
  - IDLE: `conv_reset` is 0. If any `req` bit is set, pick the first set bit searching upward from `last_grant`+1 with wrap-around. Latch the index into `sel` and its `req_data` slice into `conv_intin`, then go to LOAD.
  - LOAD, one cycle: `conv_reset` is 1 and `conv_intin` is stable. Clear the watchdog counter, then go to WAIT.
  - WAIT: `conv_reset` is 0 and the counter increments each cycle.
    - If `conv_done` is 1, go to ACK.
    - Otherwise, once the counter reaches `TIMEOUT`, set `timeout_err` and go to ACK with abort flagged.
  - ACK, one cycle: `ack[sel]` is 1 and `last_grant` takes `sel`. `result` takes `conv_floatout`, or 0 on abort. Then go to IDLE.
- `result` is registered on the ACK entry edge and holds its value until the next ACK.
- A requester must drop `req` in the cycle after its `ack`. If it keeps `req` high, that is a new request and is served again under round-robin order.
- Requests arriving while busy wait; none are lost because `req` is level-held.
- Reset mid-operation: return to IDLE at once with no `ack`. `conv_reset` is high during reset.
- `timeout_err` is cleared only by `reset`.

## Timing
- Throughput: one conversion per 3+L cycles, where L is the number of WAIT cycles until `conv_done` (L is 1–2 for the current converter).
- Latency, counting the cycle where `req` is sampled in IDLE as cycle 0:
  - LOAD is cycle 1.
  - WAIT covers cycles 2..1+L.
  - `ack` is high in cycle 2+L.
- `conv_done` is ignored outside WAIT. The stale `done` from a previous conversion is cleared by the LOAD pulse before WAIT samples it.
- Simultaneous events:
  - `req[i]` rising in the same cycle as `ack[j]` is seen on the next IDLE cycle.
  - `conv_done` and timeout in the same cycle: `done` wins and `timeout_err` stays unchanged.

## Structure
- Package `inttofloat_arb_pkg` holds:
  - the state enum `arb_state_t` {IDLE, LOAD, WAIT, ACK};
  - the width constants `INT_W` and `FLOAT_W`;
  - the function `clog2`, used for the `sel`, `last_grant` and counter widths.
- Sub-module `rr_picker` is purely combinational. It takes `req` and `last_grant` and returns `grant_idx` and `any`.
- The top module holds the FSM, the latches and the watchdog. The bench instantiates the real `inttofloat` against the `conv_*` ports.

## Test plan
- Single request: `req[0]`=1 with 16'h000f → `ack[0]` once, `result`=32'h41700000, `busy` low afterwards.
- All four request at once with 7fff, 8000, 0000, ffe5 → acks in order 0,1,2,3 with results 46fffe00, c7000000, 00000000, c1d80000.
- Fairness: with `last_grant`=1, `req[0]` and `req[2]` set → 2 is served before 0. A held `req[3]` is served within NREQ grants.
- Timeout: stub converter holds `done`=0 → `ack` arrives after `TIMEOUT` WAIT cycles with `result`=0 and `timeout_err`=1, which holds until reset.
- Reset during WAIT → no `ack`, state IDLE, `conv_reset` high during reset. A following request on 16'hffe5 completes with c1d80000.
- `req[1]` held high for two cycles after its `ack` → it is served a second time with the same result. No spurious `ack` to any other requester.

Source files
------------

// File: rtl/inttofloat_arbiter_pkg.sv
// Shared definitions for the inttofloat round-robin arbiter.
//   arb_state_t : arbiter FSM states
//   INT_W       : default signed sample width
//   FLOAT_W     : default IEEE-754 single result width
//   clog2       : ceiling log2, sizes the index and watchdog registers
package inttofloat_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } arb_state_t;

  localparam int INT_W   = 16;
  localparam int FLOAT_W = 32;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/inttofloat_arbiter_if.sv
// Bundle of requester-side and converter-side signals of the arbiter.
//   req/req_data            : requester samples, level-held until ack
//   ack/result              : one-hot completion pulse and float result
//   busy/timeout_err        : arbiter status
//   conv_reset/conv_intin   : load strobe and operand to the converter
//   conv_floatout/conv_done : converter result and completion flag
// master = arbiter side, slave = environment (requesters + converter).
interface inttofloat_arbiter_if import inttofloat_arb_pkg::*; #(
  parameter int NREQ        = 4,
  parameter int INT_WIDTH   = INT_W,
  parameter int FLOAT_WIDTH = FLOAT_W
);

  logic [NREQ-1:0]           req;
  logic [NREQ*INT_WIDTH-1:0] req_data;
  logic [NREQ-1:0]           ack;
  logic [FLOAT_WIDTH-1:0]    result;
  logic                      busy;
  logic                      timeout_err;
  logic                      conv_reset;
  logic [INT_WIDTH-1:0]      conv_intin;
  logic [FLOAT_WIDTH-1:0]    conv_floatout;
  logic                      conv_done;

  modport master (
    input  req, req_data, conv_floatout, conv_done,
    output ack, result, busy, timeout_err, conv_reset, conv_intin
  );

  modport slave (
    output req, req_data, conv_floatout, conv_done,
    input  ack, result, busy, timeout_err, conv_reset, conv_intin
  );

endinterface

// File: rtl/inttofloat_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req        : pending request bits
//   last_grant : index served most recently
//   grant_idx  : first set bit searching upward from last_grant+1, wrapping
//   any        : at least one request pending
module rr_picker import inttofloat_arb_pkg::*; #(
  parameter int NREQ  = 4,
  parameter int SEL_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last_grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    int idx;
    grant_idx = last_grant;
    any       = 1'b0;
    idx       = 0;
    // Walk from the farthest candidate to the nearest so the nearest set bit
    // after last_grant is the one left standing.
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (req[SEL_W'(idx)]) begin
        grant_idx = SEL_W'(idx);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inttofloat_arbiter.sv
// Round-robin scheduler sharing one multi-cycle inttofloat converter among
// NREQ requesters. A granted sample is latched onto conv_intin, loaded with a
// one-cycle conv_reset pulse, and the converter's result is returned with a
// one-cycle one-hot ack. A watchdog aborts conversions that never finish.
//   clk, reset : clock, synchronous active-high reset
//   bus        : inttofloat_arbiter_if master modport (requesters + converter)
module inttofloat_arbiter import inttofloat_arb_pkg::*; #(
  parameter int NREQ        = 4,
  parameter int INT_WIDTH   = INT_W,
  parameter int FLOAT_WIDTH = FLOAT_W,
  parameter int TIMEOUT     = 15
) (
  input logic                  clk,
  input logic                  reset,
  inttofloat_arbiter_if.master bus
);

  localparam int SEL_W = (NREQ > 1) ? clog2(NREQ) : 1;
  localparam int CNT_W = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;
  // Counter value during the last permitted WAIT cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t             state_q;
  arb_state_t             state_d;
  logic [SEL_W-1:0]       sel_q;
  logic [SEL_W-1:0]       last_grant_q;
  logic [SEL_W-1:0]       grant_idx;
  logic                   any_req;
  logic [INT_WIDTH-1:0]   intin_q;
  logic [FLOAT_WIDTH-1:0] result_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   timeout_err_q;
  logic                   cnt_hit;
  logic [NREQ-1:0]        ack_vec;

  rr_picker #(
    .NREQ  (NREQ),
    .SEL_W (SEL_W)
  ) u_picker (
    .req        (bus.req),
    .last_grant (last_grant_q),
    .grant_idx  (grant_idx),
    .any        (any_req)
  );

  assign cnt_hit = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = LOAD;
      LOAD:    state_d = WAIT;
      // done takes priority; timeout only ends WAIT when done is absent.
      WAIT:    if (bus.conv_done || cnt_hit) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      last_grant_q  <= SEL_W'(NREQ - 1);
      intin_q       <= '0;
      result_q      <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            sel_q   <= grant_idx;
            intin_q <= bus.req_data[int'(grant_idx) * INT_WIDTH +: INT_WIDTH];
          end
        end
        LOAD: cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // result is captured on the edge that enters ACK.
          if (bus.conv_done) begin
            result_q <= bus.conv_floatout;
          end else if (cnt_hit) begin
            result_q      <= '0;
            timeout_err_q <= 1'b1;
          end
        end
        ACK:     last_grant_q <= sel_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_vec = '0;
    if (state_q == ACK) ack_vec[sel_q] = 1'b1;
  end

  assign bus.ack         = ack_vec;
  assign bus.result      = result_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeout_err = timeout_err_q;
  // Held high through reset so the converter comes up cleared as well.
  assign bus.conv_reset  = reset | (state_q == LOAD);
  assign bus.conv_intin  = intin_q;

endmodule
